// File: rtl/uart_periph_pkg.sv
// Shared constants, register map and types for the UART peripheral.
package uart_periph_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned IO_SELECT  = 4;
   localparam logic [IO_SELECT-1:0] UART_SELECT = 4'hA;

   localparam logic [1:0] UART_REG_DATA   = 2'd0;
   localparam logic [1:0] UART_REG_STATUS = 2'd1;
   localparam logic [1:0] UART_REG_CTRL   = 2'd2;
   localparam logic [1:0] UART_REG_BAUD   = 2'd3;

   localparam int unsigned CTRL_TX_EN   = 0;
   localparam int unsigned CTRL_RX_EN   = 1;
   localparam int unsigned CTRL_RX_IE   = 2;
   localparam int unsigned CTRL_TX_IE   = 3;
   localparam int unsigned CTRL_ERR_CLR = 8;

   // STATUS register layout, MSB first
   typedef struct packed {
      logic tx_ovf;
      logic frame_err;
      logic rx_ovr;
      logic tx_busy;
      logic rx_empty;
      logic rx_full;
      logic tx_empty;
      logic tx_full;
   } status_t;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_periph_if.sv
// CPU system bus request/response signals seen by the UART.
interface uart_periph_if;
   import uart_periph_pkg::*;

   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wrt_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  we;
   logic                  req_valid;
   logic                  data_valid;

   modport master (output addr, wrt_data, we, req_valid, input rd_data, data_valid);
   modport slave  (input addr, wrt_data, we, req_valid, output rd_data, data_valid);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; extra pointer bit separates full from empty.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout_c,
   output logic             full_c,
   output logic             empty_c
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty_c;
   // A pop frees the slot, so a push on a full FIFO still lands
   assign do_push = push & (~full_c | do_pop);
   assign dout_c  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART: bus register file, baud generator, TX and RX engines.
module uart_periph
   import uart_periph_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned DEFAULT_DIV = 26
) (
   input  logic          clk,
   input  logic          reset,
   uart_periph_if.slave  bus,
   output logic          txd,
   input  logic          rxd,
   output logic          irq
);
   localparam int unsigned OSW = $clog2(OVERSAMPLE);
   localparam int unsigned BW  = $clog2(DATA_BITS);

   logic                 cs, accept, rd, wr;
   logic [1:0]           reg_sel;
   logic                 wr_data, wr_ctrl, wr_baud, rd_fifo, err_clr;
   logic [3:0]           ctrl;
   logic [DIV_WIDTH-1:0] div, baud_cnt;
   logic                 tick;
   logic                 rx_ovr, frame_err, tx_ovf, tx_ovf_set;
   logic                 tx_pop, tx_full, tx_empty, rx_full, rx_empty;
   logic [DATA_BITS-1:0] tx_dout, rx_dout;
   status_t              st;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                 unused_ok;

   assign cs      = (bus.addr[ADDR_WIDTH-1 -: IO_SELECT] == UART_SELECT);
   assign accept  = bus.req_valid & cs;
   assign reg_sel = bus.addr[3:2];
   assign wr      = accept & bus.we;
   assign rd      = accept & ~bus.we;
   assign wr_data = wr & (reg_sel == UART_REG_DATA);
   assign wr_ctrl = wr & (reg_sel == UART_REG_CTRL);
   assign wr_baud = wr & (reg_sel == UART_REG_BAUD);
   assign rd_fifo = rd & (reg_sel == UART_REG_DATA);
   assign err_clr = wr_ctrl & bus.wrt_data[CTRL_ERR_CLR];
   assign unused_ok = ^{bus.addr, bus.wrt_data};

   // ---------------- FIFOs ----------------
   tx_state_t            tx_state;
   rx_state_t            rx_state;
   logic                 rx_push, rx_ovr_set, frame_err_set;
   logic [DATA_BITS-1:0] rx_shreg;

   assign tx_pop     = (tx_state == TX_IDLE) & tick & ctrl[CTRL_TX_EN] & ~tx_empty;
   assign tx_ovf_set = wr_data & tx_full & ~tx_pop;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(wr_data), .pop(tx_pop),
      .din(bus.wrt_data[DATA_BITS-1:0]), .dout_c(tx_dout),
      .full_c(tx_full), .empty_c(tx_empty));

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .pop(rd_fifo),
      .din(rx_shreg), .dout_c(rx_dout),
      .full_c(rx_full), .empty_c(rx_empty));

   // ---------------- register file and bus response ----------------
   assign st = {tx_ovf, frame_err, rx_ovr, (tx_state != TX_IDLE),
                rx_empty, rx_full, tx_empty, tx_full};

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         UART_REG_DATA:   rd_mux = rx_empty ? '0 : DATA_WIDTH'(rx_dout);
         UART_REG_STATUS: rd_mux = DATA_WIDTH'(st);
         UART_REG_CTRL:   rd_mux = DATA_WIDTH'(ctrl);
         default:         rd_mux = DATA_WIDTH'(div);
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.data_valid <= 1'b0;
         bus.rd_data    <= '0;
         ctrl           <= '0;
         rx_ovr         <= 1'b0;
         frame_err      <= 1'b0;
         tx_ovf         <= 1'b0;
         irq            <= 1'b0;
      end else begin
         bus.data_valid <= accept;
         bus.rd_data    <= rd ? rd_mux : '0;
         if (wr_ctrl) ctrl <= bus.wrt_data[3:0];
         // A set in the same cycle as a clear wins
         rx_ovr    <= rx_ovr_set    | (rx_ovr    & ~err_clr);
         frame_err <= frame_err_set | (frame_err & ~err_clr);
         tx_ovf    <= tx_ovf_set    | (tx_ovf    & ~err_clr);
         irq <= (~rx_empty & ctrl[CTRL_RX_IE]) | (tx_empty & ctrl[CTRL_TX_IE]) |
                rx_ovr | frame_err | tx_ovf;
      end
   end

   // ---------------- baud generator ----------------
   assign tick = (baud_cnt == div);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div      <= DIV_WIDTH'(DEFAULT_DIV);
         baud_cnt <= '0;
      end else if (wr_baud) begin
         div      <= bus.wrt_data[DIV_WIDTH-1:0];
         baud_cnt <= '0;
      end else begin
         baud_cnt <= tick ? '0 : baud_cnt + DIV_WIDTH'(1);
      end
   end

   // ---------------- transmitter ----------------
   logic [OSW-1:0]       tx_cnt;
   logic [BW-1:0]        tx_bit;
   logic [DATA_BITS-1:0] tx_shreg;
   logic                 tx_last;

   assign tx_last = tick & (tx_cnt == OSW'(OVERSAMPLE-1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shreg <= '0;
         txd      <= 1'b1;
      end else begin
         if (tx_state != TX_IDLE && tick) tx_cnt <= tx_last ? '0 : tx_cnt + OSW'(1);
         case (tx_state)
            TX_IDLE: if (tx_pop) begin
               tx_shreg <= tx_dout;
               tx_cnt   <= '0;
               txd      <= 1'b0;
               tx_state <= TX_START;
            end
            TX_START: if (tx_last) begin
               tx_bit   <= '0;
               txd      <= tx_shreg[0];
               tx_state <= TX_DATA;
            end
            TX_DATA: if (tx_last) begin
               if (tx_bit == BW'(DATA_BITS-1)) begin
                  txd      <= 1'b1;
                  tx_state <= TX_STOP;
               end else begin
                  tx_bit   <= tx_bit + BW'(1);
                  tx_shreg <= tx_shreg >> 1;
                  txd      <= tx_shreg[1];
               end
            end
            TX_STOP: if (tx_last) tx_state <= TX_IDLE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic [1:0]     rx_sync;
   logic           rx_s, rx_last, rx_mid;
   logic [OSW-1:0] rx_cnt;
   logic [BW-1:0]  rx_bit;

   assign rx_s    = rx_sync[1];
   assign rx_last = tick & (rx_cnt == OSW'(OVERSAMPLE-1));
   assign rx_mid  = tick & (rx_cnt == OSW'(OVERSAMPLE/2-1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync       <= 2'b11;
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_shreg      <= '0;
         rx_push       <= 1'b0;
         rx_ovr_set    <= 1'b0;
         frame_err_set <= 1'b0;
      end else begin
         rx_sync       <= {rx_sync[0], rxd};
         rx_push       <= 1'b0;
         rx_ovr_set    <= 1'b0;
         frame_err_set <= 1'b0;
         if (rx_state != RX_IDLE && tick) rx_cnt <= rx_last ? '0 : rx_cnt + OSW'(1);
         case (rx_state)
            RX_IDLE: if (ctrl[CTRL_RX_EN] && !rx_s) begin
               rx_cnt   <= '0;
               rx_state <= RX_START;
            end
            // Half a bit in: confirm the start bit, realigning to mid-bit
            RX_START: if (rx_mid) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_last) begin
               rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
               if (rx_bit == BW'(DATA_BITS-1)) rx_state <= RX_STOP;
               else                            rx_bit   <= rx_bit + BW'(1);
            end
            RX_STOP: if (rx_last) begin
               rx_state <= RX_IDLE;
               if (!rx_s)        frame_err_set <= 1'b1;
               else if (rx_full) rx_ovr_set    <= 1'b1;
               else              rx_push       <= 1'b1;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_periph.sv
// Directed self-checking bench for uart_periph: bus registers, TX/RX framing, errors, reset.
module tb_uart_periph;
   import uart_periph_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic txd, rxd, irq;
   logic rxd_drv = 1'b1;
   logic loop = 1'b0;
   int   checks = 0;
   int   errors = 0;

   uart_periph_if bus();

   uart_periph dut (.clk(clk), .reset(reset), .bus(bus), .txd(txd), .rxd(rxd), .irq(irq));

   always #5 clk = ~clk;
   assign rxd = loop ? txd : rxd_drv;

   localparam logic [ADDR_WIDTH-1:0] BASE = {UART_SELECT, {(ADDR_WIDTH-IO_SELECT){1'b0}}};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_access(input logic w, input logic [1:0] r, input logic [31:0] wd,
                             output logic [31:0] rdv);
      logic [31:0] a;
      a = BASE;
      a[3:2] = r;
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.we = w; bus.addr = a; bus.wrt_data = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.we = 1'b0;
      rdv = bus.rd_data;
      check("data_valid_pulse", 32'(bus.data_valid), 32'd1);
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] wd);
      logic [31:0] dummy;
      bus_access(1'b1, r, wd, dummy);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] r, input logic [31:0] exp);
      logic [31:0] v;
      bus_access(1'b0, r, 32'd0, v);
      check(tag, v, exp);
   endtask

   // Leaves the caller in the first cycle txd is low
   task automatic wait_tx_start();
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (txd !== 1'b0 && n < 400);
      check("tx_start_seen", 32'(txd === 1'b0), 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rxd_drv = f[k];
         repeat (16) @(posedge clk);
      end
      rxd_drv = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0]  frame;
      logic [31:0] v;

      bus.req_valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wrt_data = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("reset_txd", 32'(txd), 32'd1);
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_data_valid", 32'(bus.data_valid), 32'd0);
      check("reset_rd_data", bus.rd_data, 32'd0);
      reset = 1'b1;

      rd_check("status_after_reset", UART_REG_STATUS, 32'h0A);
      rd_check("baud_after_reset", UART_REG_BAUD, 32'd26);
      @(posedge clk); #1;
      check("data_valid_drops", 32'(bus.data_valid), 32'd0);
      check("rd_data_drops", bus.rd_data, 32'd0);

      // Request outside the UART window is ignored
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.we = 1'b0; bus.addr = 32'h1000_0004;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("no_cs_no_response", 32'(bus.data_valid), 32'd0);

      // Transmit 0x55 at div=0: 16 clk per bit
      wr(UART_REG_BAUD, 32'd0);
      wr(UART_REG_CTRL, 32'h1);
      rd_check("ctrl_readback", UART_REG_CTRL, 32'h1);
      wr(UART_REG_DATA, 32'h55);
      wait_tx_start();
      frame = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 160; i++) begin
         check("tx_55_bit", 32'(txd), 32'(frame[i/16]));
         @(posedge clk); #1;
      end
      rd_check("status_tx_done", UART_REG_STATUS, 32'h0A);

      // Loopback 0xA3
      loop = 1'b1;
      repeat (4) @(posedge clk);
      wr(UART_REG_CTRL, 32'h3);
      wr(UART_REG_DATA, 32'hA3);
      rd_check("status_tx_busy", UART_REG_STATUS, 32'h1A);
      for (int i = 0; i < 200; i++) begin
         bus_access(1'b0, UART_REG_STATUS, 32'd0, v);
         if (v[3] == 1'b0) break;
      end
      check("loop_rx_nonempty", 32'(v[3]), 32'd0);
      repeat (20) @(posedge clk);
      rd_check("status_rx_one", UART_REG_STATUS, 32'h02);
      wr(UART_REG_CTRL, 32'h7);
      repeat (2) @(posedge clk); #1;
      check("irq_rx_ie", 32'(irq), 32'd1);
      rd_check("loop_rx_data", UART_REG_DATA, 32'hA3);
      repeat (2) @(posedge clk); #1;
      check("irq_rx_drained", 32'(irq), 32'd0);
      rd_check("status_rx_empty_again", UART_REG_STATUS, 32'h0A);
      wr(UART_REG_CTRL, 32'h3);
      loop = 1'b0;

      // 6-clk glitch is rejected silently
      @(posedge clk); #1;
      rxd_drv = 1'b0;
      repeat (6) @(posedge clk); #1;
      rxd_drv = 1'b1;
      repeat (40) @(posedge clk);
      rd_check("status_after_glitch", UART_REG_STATUS, 32'h0A);

      // Bad stop bit -> frame_err, nothing stored; clear via CTRL[8]
      send_frame(8'h3C, 1'b0);
      repeat (40) @(posedge clk);
      rd_check("status_frame_err", UART_REG_STATUS, 32'h4A);
      #1;
      check("irq_on_error", 32'(irq), 32'd1);
      wr(UART_REG_CTRL, 32'h103);
      rd_check("status_err_cleared", UART_REG_STATUS, 32'h0A);
      check("irq_after_clear", 32'(irq), 32'd0);

      // 17 characters into a 16-deep RX FIFO
      for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
      repeat (40) @(posedge clk);
      rd_check("status_rx_overrun", UART_REG_STATUS, 32'h26);
      for (int i = 0; i < 16; i++) rd_check("rx_fifo_order", UART_REG_DATA, 32'(8'h10 + i));
      rd_check("status_rx_drained", UART_REG_STATUS, 32'h2A);
      rd_check("read_empty_fifo", UART_REG_DATA, 32'd0);

      // 17 writes with tx disabled -> tx_full and tx_ovf
      wr(UART_REG_CTRL, 32'h100);
      for (int i = 0; i < 17; i++) wr(UART_REG_DATA, 32'(8'h40 + i));
      rd_check("status_tx_overflow", UART_REG_STATUS, 32'h89);

      // Reset in the middle of a frame
      wr(UART_REG_CTRL, 32'h1);
      wait_tx_start();
      repeat (20) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("midframe_reset_txd", 32'(txd), 32'd1);
      check("midframe_reset_irq", 32'(irq), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      rd_check("status_post_reset", UART_REG_STATUS, 32'h0A);
      rd_check("baud_post_reset", UART_REG_BAUD, 32'd26);
      rd_check("ctrl_post_reset", UART_REG_CTRL, 32'd0);
      repeat (50) @(posedge clk); #1;
      check("txd_idle_post_reset", 32'(txd), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
Parameterised memory-mapped UART peripheral, second generation, on the CPU system bus.
Provides a TX path and an RX path, each with its own synchronous FIFO.
Adds a programmable baud divisor, 16x-oversampled receive, error flags and a status/control register file.
The block decodes its own chip select from the upper address bits against `UART_SELECT.

Parameters:
DATA_BITS, 8, UART character width (5..9); the FIFOs store DATA_BITS bits.
FIFO_DEPTH, 16, entries per FIFO; power of two, >=2.
OVERSAMPLE, 16, baud ticks per bit; even, >=4.
DIV_WIDTH, 16, width of the baud divisor register.
DEFAULT_DIV, 26, divisor value loaded on reset.

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_WIDTH  bus address; [ADDR_WIDTH-1 -: IO_SELECT] is chip select, [3:2] selects the register
wrt_data  in  DATA_WIDTH  bus write data
rd_data  out  DATA_WIDTH  registered read data; zero when not responding
we  in  1  1 = write, 0 = read
req_valid  in  1  bus request strobe
data_valid  out  1  one-cycle response pulse
txd  out  1  serial out; idles high
rxd  in  1  serial in; asynchronous
irq  out  1  level interrupt: (rx_nonempty & rx_ie) | (tx_empty & tx_ie) | err

Behaviour:
- Reset (asserted low, async):
  - txd=1, data_valid=0, rd_data=0, irq=0.
  - Both FIFOs empty; CTRL=0; error flags 0; div=DEFAULT_DIV.
  - Reset mid-frame aborts the frame immediately; both FSMs go to IDLE.
- Bus access: accepted when req_valid & cs.
  - data_valid=1 exactly one cycle later; rd_data is valid in that same cycle and returns to 0 afterwards.
  - No back-pressure: every request is answered.
- Register map (addr[3:2]):
  - 0 DATA. Write pushes wrt_data[DATA_BITS-1:0] to the TX FIFO; if the FIFO is full the write is dropped and sticky tx_ovf is set. Read pops the RX FIFO; if the FIFO is empty the read returns 0 and does not pop.
  - 1 STATUS (read-only). Bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] rx_ovr, [6] frame_err, [7] tx_ovf.
  - 2 CTRL. Bits: [0] tx_en, [1] rx_en, [2] rx_ie, [3] tx_ie. Writing 1 to [8] clears all sticky errors. CTRL reads back bits [3:0].
  - 3 BAUD_DIV. R/W, DIV_WIDTH bits. A write resets the baud counter.
- Baud generator:
  - Counter runs 0..div; tick pulses one cycle when it wraps.
  - Bit time = OVERSAMPLE*(div+1) clk cycles.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE -> START on a tick with tx_en & !tx_empty. The FIFO is popped in that cycle; txd=0.
  - Each state lasts OVERSAMPLE ticks.
  - DATA shifts LSB first for DATA_BITS bits; STOP drives txd=1.
  - tx_busy = state != IDLE.
  - Clearing tx_en mid-frame finishes the current frame.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - IDLE -> START on a synced falling level with rx_en.
  - START: after OVERSAMPLE/2 ticks, rxd still 0 -> DATA; otherwise a glitch -> IDLE with no flag.
  - DATA samples every OVERSAMPLE ticks (mid-bit), LSB first.
  - STOP samples at mid-bit:
    - rxd=0 -> frame_err set, character discarded.
    - RX FIFO full -> rx_ovr set, character discarded.
    - Otherwise push the character.
  - Return to IDLE after the stop sample.
- FIFO corner cases:
  - Push and pop in the same cycle on a full FIFO: both occur.
  - Pop on an empty FIFO is ignored; a simultaneous push still occurs.
  - Pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.
- Error and CPU precedence: a sticky-error set and a clear in the same cycle leaves the flag set. A CPU pop and an RX push in the same cycle both occur.

Decomposition:
- Shared header (system_param.vh): UART_SELECT, IO_SELECT, register offsets UART_REG_DATA/STATUS/CTRL/BAUD, STATUS and CTRL bit indices.
- Sub-module uart_sync_fifo (WIDTH, DEPTH), single clock, instantiated twice.
- Baud generator, TX FSM and RX FSM stay in uart_periph.

Test Plan:
- Reset, then read STATUS -> 0x0A (tx_empty, rx_empty), txd=1. Read BAUD_DIV -> 26.
- BAUD_DIV=0, CTRL=0x1, write DATA=0x55 -> txd shows 0,1,0,1,0,1,0,1,0,1, each bit 16 clk wide. tx_busy clears after 160 clk.
- Loop txd to rxd, CTRL=0x3, send 0xA3 -> RX FIFO holds 0xA3. Read DATA -> 0xA3, then STATUS[3]=1.
- Drive rxd low for 6 clk (div=0) -> no push, no flag. Frame 0x3C with stop bit 0 -> frame_err=1, RX FIFO empty. Write CTRL bit 8 -> frame_err=0.
- Receive 17 characters with no reads -> rx_full, rx_ovr=1, first 16 read back in order. Write 17 DATA with tx_en=0 -> tx_ovf=1.
- Assert reset mid-TX-frame -> txd=1 in the same cycle, FIFOs empty. After release, resumes idle.
